// File: rtl/onchip_ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port on-chip RAM with
// one-cycle read latency; accesses beyond DEPTH are swallowed and flagged.
module onchip_ram_arbiter #(
  parameter int                ADDR_W   = 14,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 10000,
  parameter logic [DATA_W-1:0] OOR_DATA = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     a_address,
  input  logic [DATA_W/8-1:0]   a_byteenable,
  input  logic                  a_read,
  input  logic                  a_write,
  input  logic [DATA_W-1:0]     a_writedata,
  output logic                  a_waitrequest,
  output logic [DATA_W-1:0]     a_readdata,
  output logic                  a_readdatavalid,
  input  logic [ADDR_W-1:0]     b_address,
  input  logic [DATA_W/8-1:0]   b_byteenable,
  input  logic                  b_read,
  input  logic                  b_write,
  input  logic [DATA_W-1:0]     b_writedata,
  output logic                  b_waitrequest,
  output logic [DATA_W-1:0]     b_readdata,
  output logic                  b_readdatavalid,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W/8-1:0]   ram_byteenable,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [DATA_W-1:0]     ram_writedata,
  output logic                  ram_clken,
  input  logic [DATA_W-1:0]     ram_readdata,
  output logic                  oor_error,
  input  logic                  oor_clear
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic run_q;
  logic last_b;
  logic rd_pending;
  logic rd_port_b;
  logic rd_oor;
  logic oor_q;

  logic req_a, req_b;
  logic grant_a, grant_b, grant_any;
  logic oor_a, oor_b;
  logic sel_oor, sel_read, sel_write, rd_accept;
  logic [DATA_W-1:0] rd_data;

  assign req_a = a_read | a_write;
  assign req_b = b_read | b_write;
  assign oor_a = {1'b0, a_address} >= DEPTH_L;
  assign oor_b = {1'b0, b_address} >= DEPTH_L;

  // run_q holds both ports off until the first edge after reset release
  assign grant_a   = run_q & req_a & (~req_b | last_b);
  assign grant_b   = run_q & req_b & ~grant_a;
  assign grant_any = grant_a | grant_b;

  assign a_waitrequest = ~grant_a;
  assign b_waitrequest = ~grant_b;

  assign sel_oor   = grant_b ? oor_b   : oor_a;
  assign sel_read  = grant_b ? b_read  : a_read;
  assign sel_write = grant_b ? b_write : a_write;
  assign rd_accept = grant_any & sel_read & ~sel_write;

  assign ram_address    = grant_b ? b_address    : a_address;
  assign ram_byteenable = grant_b ? b_byteenable : a_byteenable;
  assign ram_writedata  = grant_b ? b_writedata  : a_writedata;
  assign ram_chipselect = grant_any & ~sel_oor;
  assign ram_write      = ram_chipselect & sel_write;
  assign ram_clken      = run_q;

  assign rd_data         = rd_oor ? OOR_DATA : ram_readdata;
  assign a_readdatavalid = rd_pending & ~rd_port_b;
  assign b_readdatavalid = rd_pending & rd_port_b;
  assign a_readdata      = a_readdatavalid ? rd_data : '0;
  assign b_readdata      = b_readdatavalid ? rd_data : '0;
  assign oor_error       = oor_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      last_b     <= 1'b1;
      rd_pending <= 1'b0;
      rd_port_b  <= 1'b0;
      rd_oor     <= 1'b0;
      oor_q      <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      rd_pending <= rd_accept;
      if (grant_any) last_b <= grant_b;
      if (rd_accept) begin
        rd_port_b <= grant_b;
        rd_oor    <= sel_oor;
      end
      // a new out-of-range access wins over a clear in the same cycle
      if (grant_any & sel_oor) oor_q <= 1'b1;
      else if (oor_clear)      oor_q <= 1'b0;
    end
  end

endmodule

// File: doc/onchip_ram_arbiter.md
Name: onchip_ram_arbiter

Overview:
- Two-requester round-robin arbiter in front of the single-port 32-bit on-chip RAM (10000 words, 14-bit word address, byte enables, one-cycle read latency).
- Lets the Nios data master (port a) and a DMA/LED-pattern engine (port b) share the RAM.
- Each side is an Avalon-MM pipelined slave with waitrequest and readdatavalid; one RAM access issues per clock.
- Also does range checking against DEPTH.

Parameters:
- ADDR_W, 14, word-address width on both requester ports and the RAM port.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- DEPTH, 10000, number of implemented words; addresses >= DEPTH are out of range.
- OOR_DATA, 32'h0000_0000, readdata returned for out-of-range reads.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- a_address  in  ADDR_W  port a word address.
- a_byteenable  in  DATA_W/8  port a byte lanes.
- a_read  in  1  port a read request.
- a_write  in  1  port a write request.
- a_writedata  in  DATA_W  port a write data.
- a_waitrequest  out  1  high = port a request not accepted this cycle.
- a_readdata  out  DATA_W  port a read data.
- a_readdatavalid  out  1  port a read data qualifier.
- b_address, b_byteenable, b_read, b_write, b_writedata, b_waitrequest, b_readdata, b_readdatavalid: identical to the a_ signals, for port b.
- ram_address  out  ADDR_W  to RAM address.
- ram_byteenable  out  DATA_W/8  to RAM byteenable.
- ram_chipselect  out  1  to RAM chipselect.
- ram_write  out  1  to RAM write.
- ram_writedata  out  DATA_W  to RAM writedata.
- ram_clken  out  1  to RAM clken.
- ram_readdata  in  DATA_W  from RAM readdata; valid the cycle after the address is issued.
- oor_error  out  1  sticky out-of-range access flag.
- oor_clear  in  1  synchronous clear of oor_error.

Behaviour:
- Reset (reset_n low, asynchronous):
  - last_grant = b, so a wins the first contention.
  - rd_pending = 0, rd_port = a, rd_oor = 0, oor_error = 0.
  - ram_clken = 0 while in reset, 1 from the first clock after release.
  - Both waitrequests = 1 while in reset.
  - Both readdatavalids = 0.
- A request on port x is req_x = x_read | x_write.
- Grant (combinational, same cycle):
  - Only one port requesting: that port is granted.
  - Both requesting: grant the port opposite last_grant.
  - Neither requesting: no grant; ram_chipselect = 0, ram_write = 0.
- Acceptance:
  - x_waitrequest = ~grant_x. Grant requires req_x, so waitrequest is high for an idle port.
  - A transaction is accepted when req_x & ~x_waitrequest.
  - last_grant updates to x on the clock edge of each acceptance.
- Issue: on a granted cycle, ram_address, ram_byteenable and ram_writedata mux from the granted port, ram_chipselect = 1, ram_write = x_write.
- Simultaneous read & write on one port: write wins; no read response is produced.
- Out-of-range (address >= DEPTH):
  - ram_chipselect and ram_write forced 0.
  - Transaction is still accepted (no stall).
  - oor_error sets on the next edge.
- Read pipeline:
  - On an accepted read, rd_pending <= 1, rd_port <= x, rd_oor <= out-of-range; otherwise rd_pending <= 0.
  - Next cycle, rd_port's readdatavalid = rd_pending and its readdata = rd_oor ? OOR_DATA : ram_readdata.
  - The non-selected port's readdata = 0.
  - Fixed latency is 1 cycle; back-to-back reads give one valid per cycle, in order.
- Read-during-write: RAM behaviour is DONT_CARE, so the arbiter adds no forwarding. A read issued the cycle after a write to the same address returns the new data.
- oor_error: set takes priority over oor_clear in the same cycle.
- Reset mid-read: the pending readdatavalid is dropped; no response after reset release.
- Throughput: 100% RAM utilisation when requests are continuous. Under constant contention, grants alternate a, b, a, b.

Test Plan:
- Port a writes 32'hCAFE_0001 to address 5 with byteenable 4'hF, then reads address 5 → a_waitrequest = 0 in both cycles; a_readdatavalid = 1 one cycle after the read with a_readdata = 32'hCAFE_0001; b_readdatavalid stays 0.
- Both ports read continuously for 8 cycles (a at addr 0..3, b at addr 100..103) from reset → grants a, b, a, b, ...; each port sees waitrequest high on alternate cycles; readdatavalid alternates a, b with matching data.
- Port b writes 32'h1122_3344 to address 7 with byteenable 4'b0101 over a prior value of 0 → readback = 32'h0022_0044.
- Port a reads address 10000 → a_readdata = OOR_DATA one cycle later; ram_chipselect = 0; oor_error = 1 until oor_clear is pulsed; a write to 12000 leaves RAM contents unchanged.
- Assert reset_n low in the cycle after an accepted read → no readdatavalid emerges; waitrequests are high during reset; the first contention after release is granted to a.
- Port a asserts read and write together to address 3 with data 32'hA5A5_A5A5 → the write is performed, no a_readdatavalid follows, and a later read of address 3 returns 32'hA5A5_A5A5.
